irda_receiver: RTL and testbench
================================

IRDA_RECEIVER -- requirements
Module: irda_receiver

Interface
REQ-001 Parameter: DIV, 27, clk cycles per 1/16-bit tick (>=2; 27 = 115200 baud at 50 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  block enable; low freezes all internal state.
REQ-005 rxir  input  1  IR detector output, asynchronous; high = light pulse.
REQ-006 data  output  8  last correctly received byte.
REQ-007 valid  output  1  one-cycle strobe: data updated with a good frame.
REQ-008 frame_err  output  1  one-cycle strobe: stop-bit violation, frame discarded.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 The block SHALL pass rxir through a 2-flop synchronizer (rxs); all decisions use rxs only.
REQ-011 Frame format SHALL be IrDA SIR: 10 bit windows of 16 ticks each (start, D0..D7 LSB first, stop); a window containing any rxs-high clock = logic 0; no pulse = logic 1.
REQ-012 States SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: busy=0; prescaler, tick counter (0..15), bit counter (0..7), pulse flag held at 0; the first clock with rxs=1 (cycle T0) SHALL move to START with all counters at 0 and the pulse flag set.
REQ-014 Prescaler SHALL count 0..DIV-1 while busy and ena=1; tick = prescaler at DIV-1; tick counter increments per tick, wrapping 15->0; a window ends on the tick where tick counter = 15.
REQ-015 Pulse flag SHALL set on any clock with rxs=1 inside a window, including the window's final clock, and clear at window end after being consumed.
REQ-016 START end of window: transition to DATA; the start bit is not re-checked.
REQ-017 DATA end of window: shift ~pulse_flag into the byte shift register at bit 7 (right shift, LSB first); after the 8th window, transition to STOP.
REQ-018 STOP end of window: flag clear -> data <= shift register, valid=1; flag set -> frame_err=1, data unchanged; both cases go to IDLE.
REQ-019 valid/frame_err SHALL be registered and asserted for exactly the one cycle T0 + 160*DIV; never both high.
REQ-020 Return to IDLE SHALL coincide with the valid/frame_err cycle; a new start is accepted from the following cycle (back-to-back frames supported).
REQ-021 ena=0 SHALL hold state, counters, flag, shift register and data; pulses during ena=0 are ignored; valid/frame_err forced 0; a completion falling on a disabled cycle occurs on the next enabled cycle.
REQ-022 busy SHALL be 1 in START, DATA, STOP.
REQ-023 Pulses spanning a window boundary SHALL count in every window they touch.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE, zero all counters, flag and shift register; data=0x00, valid=0, frame_err=0, busy=0 from the next cycle; synchronizer flops cleared.
REQ-025 rst has priority over ena; reset mid-frame aborts without any valid or frame_err strobe.

Verification (DIV=4, pulse width 3 ticks = 12 clk, pulses at start of each 0-bit window)
REQ-026 Frame 0xA5 -> valid=1 only at T0+640, data=0xA5, frame_err=0, busy high T0+1..T0+640.
REQ-027 Frames 0x00 then 0xFF back-to-back (second start at T0+644) -> two valid strobes, data 0x00 then 0xFF.
REQ-028 Frame 0x3C with extra pulse in stop window -> frame_err=1 at T0+640, valid=0, data keeps previous value.
REQ-029 Frame 0x81 with ena=0 for 100 cycles starting T0+200 -> valid at T0+740, data=0x81; pulses injected while disabled ignored.
REQ-030 rst=0 at T0+300 mid-frame -> busy=0, data=0x00 next cycle, no strobe; next frame 0x5A received normally.
REQ-031 1-clk pulse on last clock of window 3 -> D2 reads 0; pulse spanning window boundary 4/5 -> D3 and D4 read 0.

Source files
------------

// File: rtl/irda_if.sv
// Receiver-side signal bundle for the IrDA SIR receiver: enable and raw IR in,
// decoded byte with its completion strobes out.
`timescale 1ns/1ps
interface irda_if;
  logic       ena;
  logic       rxir;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ena,
    input  rxir,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output ena,
    output rxir,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/irda_receiver.sv
// IrDA SIR receiver: any detector pulse inside a 16-tick bit window decodes as 0,
// a dark window as 1; start, eight data bits LSB first, then a dark stop window.
`timescale 1ns/1ps
module irda_receiver #(
  parameter int DIV = 27
) (
  input  logic   clk,
  input  logic   rst,
  irda_if.master bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rxs;
  logic [PW-1:0]   presc, presc_nxt;
  logic [3:0]      tick_cnt, tick_cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic            pulse, pulse_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [7:0]      data_q, data_nxt;
  logic            valid_q, valid_nxt;
  logic            ferr_q, ferr_nxt;
  logic            tick;
  logic            win_end;
  logic            seen;

  // Synchronizer runs regardless of ena; only the frame logic freezes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b0;
      rxs     <= 1'b0;
    end else begin
      rx_meta <= bus.rxir;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      pulse    <= 1'b0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      pulse    <= pulse_nxt;
      shreg    <= shreg_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      ferr_q   <= ferr_nxt;
    end
  end

  assign tick    = (presc == PW'(DIV - 1));
  assign win_end = tick && (tick_cnt == 4'd15);
  // The window's last clock still counts, so the decision uses flag OR current rxs.
  assign seen    = pulse | rxs;

  always_comb begin
    state_nxt    = state;
    presc_nxt    = presc;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    pulse_nxt    = pulse;
    shreg_nxt    = shreg;
    data_nxt     = data_q;
    valid_nxt    = 1'b0;
    ferr_nxt     = 1'b0;

    if (bus.ena) begin
      if (state == IDLE) begin
        presc_nxt    = '0;
        tick_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        pulse_nxt    = 1'b0;
        if (rxs) begin
          state_nxt = START;
          pulse_nxt = 1'b1;
        end
      end else begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          tick_cnt_nxt = tick_cnt + 4'd1;
        end
        pulse_nxt = seen;

        if (win_end) begin
          pulse_nxt = 1'b0;
          case (state)
            START: begin
              state_nxt   = DATA;
              bit_cnt_nxt = '0;
            end
            DATA: begin
              shreg_nxt   = {~seen, shreg[7:1]};
              bit_cnt_nxt = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state_nxt = STOP;
              end
            end
            STOP: begin
              state_nxt = IDLE;
              if (!seen) begin
                data_nxt  = shreg;
                valid_nxt = 1'b1;
              end else begin
                ferr_nxt  = 1'b1;
              end
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_irda_receiver.sv
// Bench for irda_receiver: frames are drawn as per-cycle IR patterns, expected
// completions are queued at launch and matched against the strobes as they appear.
`timescale 1ns/1ps
module tb_irda_receiver;

  localparam int DIV   = 4;
  localparam int WIN   = 16 * DIV;
  localparam int FRAME = 10 * WIN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irda_if bus_if ();

  irda_receiver #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;
  logic pat [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // pat[k] is the rxir level driven k cycles after launch; it reaches the FSM at
  // edge T0+k, so window w spans k = 64w+1 .. 64w+64 (window 0 also has k=0).
  task automatic build(input logic [7:0] b, input bit start_pulse);
    for (int k = 0; k < 1024; k++) pat[k] = 1'b0;
    for (int k = 0; k < 12; k++) pat[k] = 1'b1;
    if (start_pulse) begin
      for (int i = 0; i < 8; i++)
        if (!b[i])
          for (int k = 0; k < 12; k++) pat[WIN * (i + 1) + 1 + k] = 1'b1;
    end
  endtask

  task automatic add_pulse(input int from, input int to);
    for (int k = from; k <= to; k++) pat[k] = 1'b1;
  endtask

  task automatic drive(input int len, input int gap_at, input bit push,
                       input bit exp_err, input logic [7:0] exp_data,
                       input int lat, input bit chk_busy);
    for (int d = 0; d < len; d++) begin
      @(posedge clk);
      #1;
      if (d == 0 && push) sb.push_back('{exp_err, exp_data, cyc + 3 + lat});
      if (gap_at >= 0 && d >= gap_at && d < gap_at + 100)
        bus_if.rxir = 1'($urandom_range(0, 1));
      else if (gap_at >= 0 && d >= gap_at + 100)
        bus_if.rxir = pat[d - 100];
      else
        bus_if.rxir = pat[d];
      bus_if.ena = !(gap_at >= 0 && d >= gap_at + 2 && d < gap_at + 102);
      if (chk_busy) begin
        if (d == 2)   check("busy_before_start", bus_if.busy, 1'b0);
        if (d == 4)   check("busy_early",        bus_if.busy, 1'b1);
        if (d == 642) check("busy_late",         bus_if.busy, 1'b1);
        if (d == 643) check("busy_after_frame",  bus_if.busy, 1'b0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < n; d++) begin
      @(posedge clk);
      #1;
      bus_if.rxir = 1'b0;
      bus_if.ena  = 1'b1;
    end
  endtask

  // Completion monitor: every strobe must match the head of the scoreboard.
  always begin
    @(posedge clk);
    #2;
    if (bus_if.valid || bus_if.frame_err) begin
      check("strobe_exclusive", bus_if.valid & bus_if.frame_err, 1'b0);
      if (sb.size() == 0) begin
        check("spurious_strobe", {bus_if.valid, bus_if.frame_err}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_cycle", cyc, mon_e.cycle);
        check("frame_err",    bus_if.frame_err, mon_e.err);
        check("valid",        bus_if.valid, !mon_e.err);
        check("data",         bus_if.data, mon_e.data);
      end
    end
  end

  initial begin
    bus_if.rxir = 1'b0;
    bus_if.ena  = 1'b1;
    rst         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",      bus_if.data, 8'h00);
    check("rst_valid",     bus_if.valid, 1'b0);
    check("rst_frame_err", bus_if.frame_err, 1'b0);
    check("rst_busy",      bus_if.busy, 1'b0);
    rst = 1'b1;
    idle(10);

    // Plain frame with busy profile
    build(8'hA5, 1'b1);
    drive(FRAME + 4, -1, 1'b1, 1'b0, 8'hA5, FRAME, 1'b1);
    idle(20);

    // Back-to-back: second start lands 644 cycles after the first
    build(8'h00, 1'b1);
    drive(FRAME + 4, -1, 1'b1, 1'b0, 8'h00, FRAME, 1'b0);
    build(8'hFF, 1'b1);
    drive(FRAME + 4, -1, 1'b1, 1'b0, 8'hFF, FRAME, 1'b0);
    idle(20);
    check("data_after_b2b", bus_if.data, 8'hFF);

    // Light in the stop window: frame rejected, byte retained
    build(8'h3C, 1'b1);
    add_pulse(600, 611);
    drive(FRAME + 4, -1, 1'b1, 1'b1, 8'hFF, FRAME, 1'b0);
    idle(20);
    check("data_kept_on_err", bus_if.data, 8'hFF);

    // 100-cycle disable mid-frame, with noise while disabled
    build(8'h81, 1'b1);
    drive(FRAME + 104, 200, 1'b1, 1'b0, 8'h81, FRAME + 100, 1'b0);
    idle(20);

    // Reset at T0+300 aborts silently
    build(8'h77, 1'b1);
    drive(303, -1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    rst         = 1'b0;
    bus_if.rxir = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy",  bus_if.busy, 1'b0);
    check("abort_data",  bus_if.data, 8'h00);
    check("abort_valid", bus_if.valid, 1'b0);
    rst = 1'b1;
    idle(700);
    build(8'h5A, 1'b1);
    drive(FRAME + 4, -1, 1'b1, 1'b0, 8'h5A, FRAME, 1'b0);
    idle(20);

    // Single-clock pulse on window 3's last clock; pulse across windows 4/5
    build(8'hFF, 1'b1);
    add_pulse(4 * WIN, 4 * WIN);
    add_pulse(5 * WIN - 2, 5 * WIN + 3);
    drive(FRAME + 4, -1, 1'b1, 1'b0, 8'hE3, FRAME, 1'b0);

    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(posedge clk);
    idle(5);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
